// File: rtl/track_result_sequencer_if.sv
// rtl/track_result_sequencer_if.sv - frame input, shared divider/sqrt handshakes and published results
interface track_result_sequencer_if;
   logic        frame_end;
   logic [31:0] size_in;
   logic [31:0] sum_x_in;
   logic [31:0] sum_y_in;
   logic        div_req_valid;
   logic        div_req_ready;
   logic [31:0] div_dividend;
   logic [31:0] div_divisor;
   logic        div_rsp_valid;
   logic [31:0] div_quotient;
   logic        sqrt_req_valid;
   logic        sqrt_req_ready;
   logic [31:0] sqrt_data;
   logic        sqrt_rsp_valid;
   logic [15:0] sqrt_root;
   logic [10:0] x_center;
   logic [9:0]  y_center;
   logic [15:0] radius;
   logic        target_found;
   logic        result_valid;
   logic        busy;
   logic        frame_dropped;

   modport master (
      input  frame_end, size_in, sum_x_in, sum_y_in,
      input  div_req_ready, div_rsp_valid, div_quotient,
      input  sqrt_req_ready, sqrt_rsp_valid, sqrt_root,
      output div_req_valid, div_dividend, div_divisor,
      output sqrt_req_valid, sqrt_data,
      output x_center, y_center, radius, target_found,
      output result_valid, busy, frame_dropped
   );

   modport slave (
      output frame_end, size_in, sum_x_in, sum_y_in,
      output div_req_ready, div_rsp_valid, div_quotient,
      output sqrt_req_ready, sqrt_rsp_valid, sqrt_root,
      input  div_req_valid, div_dividend, div_divisor,
      input  sqrt_req_valid, sqrt_data,
      input  x_center, y_center, radius, target_found,
      input  result_valid, busy, frame_dropped
   );
endinterface

// File: rtl/track_result_sequencer.sv
// rtl/track_result_sequencer.sv - per-frame centroid/radius sequencer over shared divider and sqrt cores
// Optional TRACK_SMOOTH_EN: published values averaged with the previous found frame.
module track_result_sequencer #(
   parameter int MIN_SIZE = 64,
   parameter int AREA_NUM = 7,
   parameter int AREA_DEN = 22
) (
   input  logic                       clk,
   input  logic                       rst_in,
   track_result_sequencer_if.master   bus
);
   localparam int          MIN_EFF = (MIN_SIZE < 1) ? 1 : MIN_SIZE;
   localparam logic [31:0] MIN_V   = 32'(MIN_EFF);
   localparam logic [31:0] DEN_V   = 32'(AREA_DEN);
   localparam logic [34:0] NUM_V   = 35'(AREA_NUM);

   typedef enum logic [3:0] {
      S_IDLE, S_DX_REQ, S_DX_WAIT, S_DY_REQ, S_DY_WAIT,
      S_DR_REQ, S_DR_WAIT, S_SQ_REQ, S_SQ_WAIT, S_PUBLISH
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [31:0] r_size;
   logic [31:0] r_sum_x;
   logic [31:0] r_sum_y;
   logic        r_found;
   logic [10:0] r_x_sh;
   logic [9:0]  r_y_sh;
   logic [31:0] r_r2;
   logic [15:0] r_rad_sh;
   logic [10:0] r_x_center;
   logic [9:0]  r_y_center;
   logic [15:0] r_radius;
   logic        r_target_found;
   logic        r_result_valid;
   logic        r_frame_dropped;

   logic        w_size_ok;
   logic [34:0] w_prod;
   logic [31:0] w_r2_num;
   logic [10:0] w_xq;
   logic [9:0]  w_yq;
   logic [10:0] w_pub_x;
   logic [9:0]  w_pub_y;
   logic [15:0] w_pub_r;
   logic        w_div_req_valid;
   logic [31:0] w_dividend;
   logic [31:0] w_divisor;
   logic        w_sqrt_req_valid;

   assign w_size_ok = (bus.size_in >= MIN_V);
   assign w_prod    = {3'b000, r_size} * NUM_V;
   assign w_r2_num  = (|w_prod[34:32]) ? 32'hFFFF_FFFF : w_prod[31:0];
   assign w_xq      = (bus.div_quotient > 32'd2047) ? 11'h7FF : bus.div_quotient[10:0];
   assign w_yq      = (bus.div_quotient > 32'd1023) ? 10'h3FF : bus.div_quotient[9:0];

`ifdef TRACK_SMOOTH_EN
   logic [11:0] w_avg_x;
   logic [10:0] w_avg_y;
   logic [16:0] w_avg_r;
   assign w_avg_x = {1'b0, r_x_center} + {1'b0, r_x_sh};
   assign w_avg_y = {1'b0, r_y_center} + {1'b0, r_y_sh};
   assign w_avg_r = {1'b0, r_radius} + {1'b0, r_rad_sh};
   // Only average against a triple that came from a found frame.
   assign w_pub_x = r_target_found ? w_avg_x[11:1] : r_x_sh;
   assign w_pub_y = r_target_found ? w_avg_y[10:1] : r_y_sh;
   assign w_pub_r = r_target_found ? w_avg_r[16:1] : r_rad_sh;
`else
   assign w_pub_x = r_x_sh;
   assign w_pub_y = r_y_sh;
   assign w_pub_r = r_rad_sh;
`endif

   always_ff @(posedge clk) begin
      if (rst_in) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (bus.frame_end) w_next = w_size_ok ? S_DX_REQ : S_PUBLISH;
         S_DX_REQ:  if (bus.div_req_ready) w_next = S_DX_WAIT;
         S_DX_WAIT: if (bus.div_rsp_valid) w_next = S_DY_REQ;
         S_DY_REQ:  if (bus.div_req_ready) w_next = S_DY_WAIT;
         S_DY_WAIT: if (bus.div_rsp_valid) w_next = S_DR_REQ;
         S_DR_REQ:  if (bus.div_req_ready) w_next = S_DR_WAIT;
         S_DR_WAIT: if (bus.div_rsp_valid) w_next = S_SQ_REQ;
         S_SQ_REQ:  if (bus.sqrt_req_ready) w_next = S_SQ_WAIT;
         S_SQ_WAIT: if (bus.sqrt_rsp_valid) w_next = S_PUBLISH;
         S_PUBLISH: w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_div_req_valid  = 1'b0;
      w_dividend       = r_sum_x;
      w_divisor        = r_size;
      w_sqrt_req_valid = 1'b0;
      case (r_state)
         S_DX_REQ: w_div_req_valid = 1'b1;
         S_DY_REQ: begin
            w_div_req_valid = 1'b1;
            w_dividend      = r_sum_y;
         end
         S_DR_REQ: begin
            w_div_req_valid = 1'b1;
            w_dividend      = w_r2_num;
            w_divisor       = DEN_V;
         end
         S_SQ_REQ: w_sqrt_req_valid = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         r_size          <= '0;
         r_sum_x         <= '0;
         r_sum_y         <= '0;
         r_found         <= 1'b0;
         r_x_sh          <= '0;
         r_y_sh          <= '0;
         r_r2            <= '0;
         r_rad_sh        <= '0;
         r_x_center      <= '0;
         r_y_center      <= '0;
         r_radius        <= '0;
         r_target_found  <= 1'b0;
         r_result_valid  <= 1'b0;
         r_frame_dropped <= 1'b0;
      end else begin
         r_result_valid  <= (r_state == S_PUBLISH);
         r_frame_dropped <= bus.frame_end && (r_state != S_IDLE);
         case (r_state)
            S_IDLE: if (bus.frame_end) begin
               r_size  <= bus.size_in;
               r_sum_x <= bus.sum_x_in;
               r_sum_y <= bus.sum_y_in;
               r_found <= w_size_ok;
            end
            S_DX_WAIT: if (bus.div_rsp_valid) r_x_sh <= w_xq;
            S_DY_WAIT: if (bus.div_rsp_valid) r_y_sh <= w_yq;
            S_DR_WAIT: if (bus.div_rsp_valid) r_r2 <= bus.div_quotient;
            S_SQ_WAIT: if (bus.sqrt_rsp_valid) r_rad_sh <= bus.sqrt_root;
            S_PUBLISH: begin
               r_target_found <= r_found;
               if (r_found) begin
                  r_x_center <= w_pub_x;
                  r_y_center <= w_pub_y;
                  r_radius   <= w_pub_r;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.div_req_valid  = w_div_req_valid;
   assign bus.div_dividend   = w_dividend;
   assign bus.div_divisor    = w_divisor;
   assign bus.sqrt_req_valid = w_sqrt_req_valid;
   assign bus.sqrt_data      = r_r2;
   assign bus.x_center       = r_x_center;
   assign bus.y_center       = r_y_center;
   assign bus.radius         = r_radius;
   assign bus.target_found   = r_target_found;
   assign bus.result_valid   = r_result_valid;
   assign bus.busy           = (r_state != S_IDLE);
   assign bus.frame_dropped  = r_frame_dropped;
endmodule

// File: tb/tb_track_result_sequencer.sv
// tb/tb_track_result_sequencer.sv - scoreboard bench with divider/sqrt core models and a frame-level reference model
module tb_track_result_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   track_result_sequencer_if bus ();
   track_result_sequencer dut (.clk(clk), .rst_in(rst), .bus(bus));

   typedef struct {
      logic        found;
      logic [10:0] x;
      logic [9:0]  y;
      logic [15:0] r;
      int          issue;
      bit          chk_lat;
   } pub_t;
   typedef struct {
      logic [31:0] dd;
      logic [31:0] dv;
   } dreq_t;

   pub_t        pub_q[$];
   dreq_t       div_q[$];
   logic [31:0] sq_q[$];

   int total = 0, bad = 0, cyc = 0;
   int pub_count = 0, obs_drops = 0, exp_drops = 0, div_hs = 0;
   int lat_force = -1, bp_hold = 0;
   bit rdy_always = 1'b1;
   logic [10:0] obs_x;
   logic [9:0]  obs_y;
   logic [15:0] obs_r;
   logic        obs_found;
   logic [10:0] m_x = '0;
   logic [9:0]  m_y = '0;
   logic [15:0] m_r = '0;
   logic        m_found = 1'b0;

   task automatic check(input string name, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic logic [15:0] isqrt(input logic [31:0] v);
      longint lo = 0, hi = 65535, mid;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= longint'(v)) lo = mid;
         else hi = mid - 1;
      end
      return 16'(lo);
   endfunction

   // Reference: what the published triple must be after this frame, plus the core requests it implies.
   task automatic push_expect(input logic [31:0] size, input logic [31:0] sx, input logic [31:0] sy);
      pub_t   e;
      longint qx, qy, r2n;
      logic [10:0] nx;
      logic [9:0]  ny;
      logic [15:0] nr;
      if (size >= 64) begin
         qx  = longint'(sx) / longint'(size);
         qy  = longint'(sy) / longint'(size);
         r2n = longint'(size) * 7;
         if (r2n > 64'hFFFF_FFFF) r2n = 64'hFFFF_FFFF;
         nx = (qx > 2047) ? 11'd2047 : 11'(qx);
         ny = (qy > 1023) ? 10'd1023 : 10'(qy);
         nr = isqrt(32'(r2n / 22));
`ifdef TRACK_SMOOTH_EN
         if (m_found) begin
            nx = 11'((int'(m_x) + int'(nx)) / 2);
            ny = 10'((int'(m_y) + int'(ny)) / 2);
            nr = 16'((int'(m_r) + int'(nr)) / 2);
         end
`endif
         m_x = nx; m_y = ny; m_r = nr;
         div_q.push_back('{dd: sx, dv: size});
         div_q.push_back('{dd: sy, dv: size});
         div_q.push_back('{dd: 32'(r2n), dv: 32'd22});
         sq_q.push_back(32'(r2n / 22));
      end
      m_found   = (size >= 64);
      e.found   = m_found;
      e.x       = m_x;
      e.y       = m_y;
      e.r       = m_r;
      e.issue   = cyc;
      e.chk_lat = !m_found;
      pub_q.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   // Monitor: publications and drop pulses.
   initial forever begin
      pub_t e;
      @(negedge clk);
      if (!rst) begin
         if (bus.frame_dropped) obs_drops++;
         if (bus.result_valid) begin
            pub_count++;
            obs_x = bus.x_center; obs_y = bus.y_center;
            obs_r = bus.radius;   obs_found = bus.target_found;
            if (pub_q.size() == 0) check("unexpected_result_valid", 1, 0);
            else begin
               e = pub_q.pop_front();
               check("x_center", bus.x_center, e.x);
               check("y_center", bus.y_center, e.y);
               check("radius", bus.radius, e.r);
               check("target_found", bus.target_found, e.found);
               if (e.chk_lat) check("nofound_latency", cyc - e.issue, 2);
            end
         end
      end
   end

   // Divider core model with random ready/latency; also checks request order and stall stability.
   initial begin
      bit          pend = 0, prev_stall = 0;
      int          cd = 0;
      logic [31:0] pq = '0, p_dd = '0, p_dv = '0;
      dreq_t       e;
      bus.div_req_ready = 1'b0; bus.div_rsp_valid = 1'b0; bus.div_quotient = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (div_q.size() == 0) check("div_valid_without_work", bus.div_req_valid, 0);
            if (prev_stall) begin
               check("div_valid_held", bus.div_req_valid, 1);
               check("div_dividend_held", bus.div_dividend, p_dd);
               check("div_divisor_held", bus.div_divisor, p_dv);
            end
            if (bus.div_req_valid && bus.div_req_ready) begin
               div_hs++;
               if (div_q.size() != 0) begin
                  e = div_q.pop_front();
                  check("div_dividend", bus.div_dividend, e.dd);
                  check("div_divisor", bus.div_divisor, e.dv);
               end
               pq   = (bus.div_divisor == 0) ? 32'hFFFF_FFFF : bus.div_dividend / bus.div_divisor;
               pend = 1;
               cd   = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
            end
            prev_stall = bus.div_req_valid && !bus.div_req_ready;
            p_dd = bus.div_dividend; p_dv = bus.div_divisor;
         end else prev_stall = 0;
         @(posedge clk); #1;
         bus.div_rsp_valid = 1'b0;
         bus.div_quotient  = $urandom;
         if (pend) begin
            if (cd == 0) begin
               bus.div_rsp_valid = 1'b1; bus.div_quotient = pq; pend = 0;
            end else cd--;
         end
         if (bp_hold > 0) begin
            bus.div_req_ready = 1'b0; bp_hold--;
         end else bus.div_req_ready = rdy_always ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      bit          pend = 0;
      int          cd = 0;
      logic [15:0] pr = '0;
      bus.sqrt_req_ready = 1'b0; bus.sqrt_rsp_valid = 1'b0; bus.sqrt_root = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (sq_q.size() == 0) check("sqrt_valid_without_work", bus.sqrt_req_valid, 0);
            if (bus.sqrt_req_valid && bus.sqrt_req_ready) begin
               if (sq_q.size() != 0) check("sqrt_data", bus.sqrt_data, sq_q.pop_front());
               pr   = isqrt(bus.sqrt_data);
               pend = 1;
               cd   = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
            end
         end
         @(posedge clk); #1;
         bus.sqrt_rsp_valid = 1'b0;
         bus.sqrt_root      = 16'($urandom);
         if (pend) begin
            if (cd == 0) begin
               bus.sqrt_rsp_valid = 1'b1; bus.sqrt_root = pr; pend = 0;
            end else cd--;
         end
         bus.sqrt_req_ready = rdy_always ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
   end

   // mode 0: no overlap; 1: extra frame_end d cycles after capture; 2: extra frame_end once DY is accepted.
   task automatic run_frame(input logic [31:0] size, input logic [31:0] sx, input logic [31:0] sy,
                            input int mode, input int d);
      int start_pub, start_hs, waited;
      bit done, inj;
      @(posedge clk); #1;
      push_expect(size, sx, sy);
      bus.frame_end = 1'b1; bus.size_in = size; bus.sum_x_in = sx; bus.sum_y_in = sy;
      @(posedge clk); #1;
      bus.frame_end = 1'b0;
      start_pub = pub_count; start_hs = div_hs; waited = 0; done = 0;
      while (pub_count == start_pub && waited < 800) begin
         inj = 0;
         if (!done && mode == 1 && waited == d - 1) inj = 1;
         if (!done && mode == 2 && div_hs - start_hs >= 2) inj = 1;
         if (inj) begin
            done = 1; exp_drops++;
            bus.frame_end = 1'b1; bus.size_in = $urandom; bus.sum_x_in = $urandom; bus.sum_y_in = $urandom;
         end
         @(posedge clk); #1;
         bus.frame_end = 1'b0;
         waited++;
      end
      check("publish_count", pub_count - start_pub, 1);
      repeat (2) @(posedge clk);
      #1;
      check("frame_dropped_count", obs_drops, exp_drops);
   endtask

   task automatic gen_frame(output logic [31:0] size, output logic [31:0] sx, output logic [31:0] sy);
      case ($urandom_range(0, 3))
         0: size = $urandom_range(0, 63);
         1: size = $urandom_range(63, 65);
         2: size = $urandom_range(64, 5000);
         default: size = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) begin
         sx = $urandom; sy = $urandom;
      end else begin
         sx = 32'(longint'(size) * $urandom_range(0, 2200));
         sy = 32'(longint'(size) * $urandom_range(0, 1100));
      end
   endtask

   initial begin
      logic [31:0] s, x, y;
      int start_pub, start_hs, w, mode;
      bus.frame_end = 1'b0; bus.size_in = '0; bus.sum_x_in = '0; bus.sum_y_in = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_x_center", bus.x_center, 0);
      check("rst_y_center", bus.y_center, 0);
      check("rst_radius", bus.radius, 0);
      check("rst_target_found", bus.target_found, 0);
      check("rst_result_valid", bus.result_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_frame_dropped", bus.frame_dropped, 0);
      check("rst_div_req_valid", bus.div_req_valid, 0);
      check("rst_sqrt_req_valid", bus.sqrt_req_valid, 0);

      rdy_always = 1; lat_force = 0;
      run_frame(32'd100, 32'd32000, 32'd24000, 0, 0);
      check("basic_x", obs_x, 320); check("basic_y", obs_y, 240);
      check("basic_r", obs_r, 5);   check("basic_found", obs_found, 1);

      run_frame(32'd10, 32'd32000, 32'd24000, 0, 0);
      check("small_x", obs_x, 320); check("small_y", obs_y, 240);
      check("small_r", obs_r, 5);   check("small_found", obs_found, 0);

      rdy_always = 0; lat_force = -1; bp_hold = 21;
      run_frame(32'd500, 32'd350000, 32'd200000, 0, 0);

      lat_force = 3;
      run_frame(32'd200, 32'd20000, 32'd10000, 2, 0);

      lat_force = -1;
      run_frame(32'd64, 32'd192000, 32'd128000, 0, 0);
      check("sat_x", obs_x, 2047); check("sat_y", obs_y, 1023);

      run_frame(32'd30, 32'd100, 32'd100, 1, 1);

      repeat (40) begin
         gen_frame(s, x, y);
         mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
         run_frame(s, x, y, mode, (s >= 64) ? int'($urandom_range(1, 8)) : 1);
      end

      // Reset while the r^2 division is outstanding; its response lands after reset.
      rdy_always = 1; lat_force = 6;
      @(posedge clk); #1;
      push_expect(32'd900, 32'd90000, 32'd45000);
      bus.frame_end = 1'b1; bus.size_in = 32'd900; bus.sum_x_in = 32'd90000; bus.sum_y_in = 32'd45000;
      @(posedge clk); #1;
      bus.frame_end = 1'b0;
      start_pub = pub_count; start_hs = div_hs; w = 0;
      while (div_hs - start_hs < 3 && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      check("dr_accept_seen", div_hs - start_hs, 3);
      rst = 1'b1;
      pub_q.delete(); div_q.delete(); sq_q.delete();
      m_x = '0; m_y = '0; m_r = '0; m_found = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      check("midrst_x_center", bus.x_center, 0);
      check("midrst_y_center", bus.y_center, 0);
      check("midrst_radius", bus.radius, 0);
      check("midrst_target_found", bus.target_found, 0);
      check("midrst_busy", bus.busy, 0);
      check("midrst_no_publish", pub_count, start_pub);

      lat_force = -1; rdy_always = 0;
      run_frame(32'd128, 32'd12800, 32'd6400, 0, 0);
      check("post_rst_x", obs_x, 100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/track_result_sequencer.md
Name: track_result_sequencer

Overview:
- Frame-level controller for the colour tracker back end.
- At each frame boundary it captures the accumulated pixel count and the x/y coordinate sums.
- It then issues the work to one shared 32-bit divider and one shared square-root core, in order: x mean, y mean, r² = size·AREA_NUM/AREA_DEN, then sqrt(r²).
- It publishes x_center, y_center and radius atomically, with a one-cycle result_valid pulse, for the overlay and motor-control logic.

Parameters:
- MIN_SIZE, 64: pixel counts below this mean "no target"; no divider or sqrt requests are issued.
- AREA_NUM, 7: numerator of the area-to-r² scale factor.
- AREA_DEN, 22: denominator of the area-to-r² scale factor (7/22 ≈ 1/π); must be nonzero.

Ports:
- clk  in  1  pixel clock (65 MHz)
- rst_in  in  1  synchronous, active-high reset
- frame_end  in  1  one-cycle pulse; the sum inputs are valid in this cycle
- size_in  in  32  thresholded pixel count for the frame
- sum_x_in  in  32  sum of hcount over thresholded pixels
- sum_y_in  in  32  sum of vcount over thresholded pixels
- div_req_valid  out  1  divider request valid
- div_req_ready  in  1  divider accepts the request
- div_dividend  out  32  divider dividend
- div_divisor  out  32  divider divisor
- div_rsp_valid  in  1  divider result valid
- div_quotient  in  32  divider quotient
- sqrt_req_valid  out  1  sqrt request valid
- sqrt_req_ready  in  1  sqrt accepts the request
- sqrt_data  out  32  sqrt operand (r²)
- sqrt_rsp_valid  in  1  sqrt result valid
- sqrt_root  in  16  integer floor root
- x_center  out  11  published x mean
- y_center  out  10  published y mean
- radius  out  16  published radius
- target_found  out  1  last published frame had size ≥ MIN_SIZE
- result_valid  out  1  one-cycle pulse when the outputs update
- busy  out  1  sequencer is not in IDLE
- frame_dropped  out  1  one-cycle pulse: frame_end arrived while busy

Behaviour:
- Reset: synchronous and active-high; one clock.
  - State goes to IDLE.
  - All outputs go to 0, including both req_valids, result_valid, busy and frame_dropped.
- States:
  - IDLE
  - DX_REQ → DX_WAIT
  - DY_REQ → DY_WAIT
  - DR_REQ → DR_WAIT
  - SQ_REQ → SQ_WAIT
  - PUBLISH
- IDLE, on frame_end:
  - Latch size_in, sum_x_in and sum_y_in.
  - If size_in ≥ MIN_SIZE, go to DX_REQ.
  - Otherwise go to PUBLISH with found=0.
- Request handshake:
  - In each *_REQ state, req_valid is high and the operands are held constant.
  - The transfer happens in the cycle where valid and ready are both high; the next state is the matching *_WAIT.
  - req_valid is never deasserted before ready.
- Operands:
  - DX: sum_x / size.
  - DY: sum_y / size.
  - DR: (size·AREA_NUM) / AREA_DEN. The product is computed at 35 bits and saturates to 32'hFFFF_FFFF if it overflows.
  - SQ: sqrt_data = r² quotient from DR.
- *_WAIT states:
  - On rsp_valid, register the quotient or root into a shadow register and advance.
  - rsp_valid seen in any other state is ignored.
- Result widths:
  - The x quotient saturates to 2047 and the y quotient to 1023 (quotient > field maximum → all ones).
  - radius = sqrt_root.
- PUBLISH (one cycle):
  - If found: copy the shadow registers to the outputs and set target_found=1.
  - If not found: x_center, y_center and radius hold their previous values, and target_found=0.
  - result_valid=1 for this cycle only; return to IDLE.
- Latency with zero-latency ready/rsp: 1 capture cycle + 4×(REQ+WAIT) + 1 PUBLISH.
- No-target path: result_valid pulses 2 cycles after frame_end.
- Outputs never change except in PUBLISH, so no partially updated triple is ever visible.
- frame_end while busy (any state other than IDLE): the new frame is discarded, frame_dropped pulses for one cycle, and the sequence in progress continues.
- frame_end in the same cycle as PUBLISH: dropped, because busy is still high.
- Divide by zero is impossible: MIN_SIZE ≥ 1 is enforced, and AREA_DEN is constant and nonzero.
- Reset mid-operation: everything returns to IDLE and in-flight core responses are ignored. Integrators must also reset the shared cores.
- busy = (state ≠ IDLE).

Optional Feature:
- Macro: TRACK_SMOOTH_EN.
- Defined, when found:
  - Each published value = (previous output + new value) >> 1, using a 1-bit wider intermediate.
  - The first found frame after reset, or after a not-found frame, publishes raw values.
- Not defined: raw values are published directly.
- Timing and handshakes are identical in both cases.

Test Plan:
- Basic frame: frame_end with size=100, sum_x=32000, sum_y=24000; cores respond with 1-cycle latency.
  - Divider sees requests in order (32000,100), (24000,100), (700,22); sqrt sees 31.
  - Outputs: x_center=320, y_center=240, radius=5, target_found=1; exactly one result_valid.
- Small blob: size=10, no other stimulus changes.
  - No req_valid ever asserts.
  - result_valid pulses 2 cycles later; target_found=0; x_center, y_center and radius keep the prior values (320, 240, 5).
- Backpressure: hold div_req_ready=0 for 20 cycles.
  - div_req_valid stays high and the operands stay stable for all 20 cycles; results are still correct.
- Overlap: second frame_end while in DY_WAIT.
  - frame_dropped pulses once; the first frame's results publish unchanged; next state is IDLE.
- Saturation: size=64, sum_x=64·3000.
  - x_center=2047.
- Reset mid-operation: rst_in in DR_WAIT, then div_rsp_valid arrives after reset.
  - All outputs are 0, busy=0, and no result_valid pulse occurs.
